fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage LoongArch32 pipeline; the producer side of the F→D interface.
- Holds the fetch PC and drives the synchronous instruction SRAM, which has 1-cycle read latency.
- Hands {pc, pc_en} plus FD_valid to the decode stage.
- Consumes the decode stage's Branch_BUS redirect, with zero-bubble redirection.
- Keeps the SRAM address stable during decode back-pressure so inst_sram_rdata stays valid for the instruction held in decode.

---
 rtl/fetch_stage.sv | 97 +++++++++
 tb/tb_fetch_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Brief    : LoongArch32 instruction-fetch stage, producer side of F->D.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int          CNT_WID  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               D_allowin,
    input  logic               DE_valid,
    input  logic               E_allowin,
    input  logic [32:0]        Branch_BUS,
    output logic               FD_valid,
    output logic [32:0]        FD_BUS,
    output logic               inst_sram_en,
    output logic [31:0]        inst_sram_addr,
    output logic [3:0]         inst_sram_we,
    output logic [31:0]        inst_sram_wdata,
    output logic [CNT_WID-1:0] cnt_fetch,
    output logic [CNT_WID-1:0] cnt_redirect,
    output logic [CNT_WID-1:0] cnt_stall
);

    localparam logic [CNT_WID-1:0] C_CNT_MAX = {CNT_WID{1'b1}};

    logic [31:0]        r_pc_f;
    logic [31:0]        r_last_pc;
    logic               r_fs_valid;
    logic [CNT_WID-1:0] r_cnt_fetch;
    logic [CNT_WID-1:0] r_cnt_redirect;
    logic [CNT_WID-1:0] r_cnt_stall;

    logic        w_br_taken;
    logic [31:0] w_br_target;
    logic        w_br_acc;
    logic [31:0] w_fpc;
    logic        w_fd_valid;
    logic        w_fire;
    logic        w_stall;

    assign w_br_taken  = Branch_BUS[32];
    assign w_br_target = Branch_BUS[31:0];
    assign w_br_acc    = w_br_taken & DE_valid & E_allowin & ~rst;
    assign w_fpc       = w_br_acc ? w_br_target : r_pc_f;

    // Outputs are forced to their reset view combinationally so that a reset
    // asserted mid-run is visible in the same cycle, not one edge later.
    assign w_fd_valid  = r_fs_valid & ~rst;
    assign w_fire      = w_fd_valid & D_allowin;
    assign w_stall     = w_fd_valid & ~D_allowin;

    assign FD_valid        = w_fd_valid;
    assign FD_BUS          = rst ? {RESET_PC, 1'b0} : {w_fpc, r_fs_valid};
    assign inst_sram_en    = ~rst;
    // Re-reading last_pc during back-pressure keeps rdata stable for decode.
    assign inst_sram_addr  = w_fire ? w_fpc : r_last_pc;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_wdata = 32'h0000_0000;

    assign cnt_fetch    = r_cnt_fetch;
    assign cnt_redirect = r_cnt_redirect;
    assign cnt_stall    = r_cnt_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_f         <= RESET_PC;
            r_last_pc      <= RESET_PC;
            r_fs_valid     <= 1'b0;
            r_cnt_fetch    <= '0;
            r_cnt_redirect <= '0;
            r_cnt_stall    <= '0;
        end else begin
            r_fs_valid <= 1'b1;
            if (w_fire) begin
                r_last_pc <= w_fpc;
                r_pc_f    <= w_fpc + 32'd4;
                if (r_cnt_fetch != C_CNT_MAX) begin
                    r_cnt_fetch <= r_cnt_fetch + 1'b1;
                end
            end
            if (w_br_acc && (r_cnt_redirect != C_CNT_MAX)) begin
                r_cnt_redirect <= r_cnt_redirect + 1'b1;
            end
            if (w_stall && (r_cnt_stall != C_CNT_MAX)) begin
                r_cnt_stall <= r_cnt_stall + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Scoreboard bench for fetch_stage (32-bit and 4-bit counter builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] C_RESET_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_allowin;
    logic        de_valid;
    logic        e_allowin;
    logic [32:0] branch_bus;

    logic        w_fd_valid,  w4_fd_valid;
    logic [32:0] w_fd_bus,    w4_fd_bus;
    logic        w_sram_en,   w4_sram_en;
    logic [31:0] w_sram_addr, w4_sram_addr;
    logic [3:0]  w_sram_we,   w4_sram_we;
    logic [31:0] w_sram_wdata, w4_sram_wdata;
    logic [31:0] w_cnt_f, w_cnt_r, w_cnt_s;
    logic [3:0]  w4_cnt_f, w4_cnt_r, w4_cnt_s;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(C_RESET_PC), .CNT_WID(32)) u_dut (
        .clk(clk), .rst(rst), .D_allowin(d_allowin), .DE_valid(de_valid),
        .E_allowin(e_allowin), .Branch_BUS(branch_bus),
        .FD_valid(w_fd_valid), .FD_BUS(w_fd_bus), .inst_sram_en(w_sram_en),
        .inst_sram_addr(w_sram_addr), .inst_sram_we(w_sram_we),
        .inst_sram_wdata(w_sram_wdata), .cnt_fetch(w_cnt_f),
        .cnt_redirect(w_cnt_r), .cnt_stall(w_cnt_s)
    );

    fetch_stage #(.RESET_PC(C_RESET_PC), .CNT_WID(4)) u_dut4 (
        .clk(clk), .rst(rst), .D_allowin(d_allowin), .DE_valid(de_valid),
        .E_allowin(e_allowin), .Branch_BUS(branch_bus),
        .FD_valid(w4_fd_valid), .FD_BUS(w4_fd_bus), .inst_sram_en(w4_sram_en),
        .inst_sram_addr(w4_sram_addr), .inst_sram_we(w4_sram_we),
        .inst_sram_wdata(w4_sram_wdata), .cnt_fetch(w4_cnt_f),
        .cnt_redirect(w4_cnt_r), .cnt_stall(w4_cnt_s)
    );

    typedef struct {
        logic        valid;
        logic [32:0] bus;
        logic        en;
        logic [31:0] addr;
        logic [31:0] cf, cr, cs;
        logic [3:0]  cf4, cs4;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: the fetch stream is "where decode last took an
    // instruction from, plus four", unless decode redirects it this cycle.
    logic [31:0] m_next_seq;
    logic [31:0] m_last_taken;
    logic        m_slot_live;
    longint      m_fetches, m_redirects, m_stalls;

    function automatic logic [3:0] sat4(longint v);
        return (v > 15) ? 4'hF : 4'(v);
    endfunction

    task automatic model_reset();
        m_next_seq   = C_RESET_PC;
        m_last_taken = C_RESET_PC;
        m_slot_live  = 1'b0;
        m_fetches    = 0;
        m_redirects  = 0;
        m_stalls     = 0;
    endtask

    task automatic step(input logic r, input logic da, input logic dv,
                        input logic ea, input logic [32:0] br);
        exp_t        e;
        logic        redirect;
        logic        take;
        logic [31:0] slot_pc;
        rst = r; d_allowin = da; de_valid = dv; e_allowin = ea; branch_bus = br;
        redirect = !r && br[32] && dv && ea;
        slot_pc  = redirect ? br[31:0] : m_next_seq;
        take     = !r && m_slot_live && da;
        e.valid  = !r && m_slot_live;
        e.bus    = r ? {C_RESET_PC, 1'b0} : {slot_pc, m_slot_live};
        e.en     = !r;
        e.addr   = take ? slot_pc : m_last_taken;
        e.cf     = 32'(m_fetches);
        e.cr     = 32'(m_redirects);
        e.cs     = 32'(m_stalls);
        e.cf4    = sat4(m_fetches);
        e.cs4    = sat4(m_stalls);
        q_exp.push_back(e);
        if (r) begin
            model_reset();
        end else begin
            if (take) begin
                m_last_taken = slot_pc;
                m_next_seq   = slot_pc + 32'd4;
                m_fetches++;
            end
            if (redirect) m_redirects++;
            if (m_slot_live && !da) m_stalls++;
            m_slot_live = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares whatever the DUTs present against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                check("FD_valid",       64'(w_fd_valid),  64'(e.valid));
                check("FD_BUS",         64'(w_fd_bus),    64'(e.bus));
                check("inst_sram_en",   64'(w_sram_en),   64'(e.en));
                check("inst_sram_addr", 64'(w_sram_addr), 64'(e.addr));
                check("inst_sram_we",   64'(w_sram_we),   64'd0);
                check("inst_sram_wdata",64'(w_sram_wdata),64'd0);
                check("cnt_fetch",      64'(w_cnt_f),     64'(e.cf));
                check("cnt_redirect",   64'(w_cnt_r),     64'(e.cr));
                check("cnt_stall",      64'(w_cnt_s),     64'(e.cs));
                check("w4_FD_BUS",      64'(w4_fd_bus),   64'(e.bus));
                check("w4_cnt_fetch",   64'(w4_cnt_f),    64'(e.cf4));
                check("w4_cnt_stall",   64'(w4_cnt_s),    64'(e.cs4));
            end
        end
    end

    initial begin
        logic        r, da, dv, ea;
        logic [32:0] br;
        int          wait_cnt;
        model_reset();
        rst = 1'b1; d_allowin = 1'b0; de_valid = 1'b0; e_allowin = 1'b0;
        branch_bus = '0;
        repeat (2) @(posedge clk);
        #1;
        step(1, 0, 0, 0, '0);
        step(0, 1, 0, 0, '0);
        repeat (3) step(0, 1, 0, 0, '0);
        repeat (5) step(0, 0, 0, 0, '0);
        step(0, 1, 0, 0, '0);
        step(0, 1, 1, 1, {1'b1, 32'h1c000100});
        step(0, 1, 0, 0, '0);
        step(0, 1, 0, 1, {1'b1, 32'h1c000100});
        step(0, 1, 1, 0, {1'b1, 32'h1c000100});
        step(0, 0, 0, 0, {1'b1, 32'h1c000100});
        step(0, 1, 1, 1, {1'b1, 32'hFFFFFFF8});
        repeat (3) step(0, 1, 0, 0, '0);
        repeat (2) step(0, 0, 0, 0, '0);
        step(1, 0, 0, 0, '0);
        step(0, 1, 0, 0, '0);
        repeat (3) step(0, 1, 0, 0, '0);
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            da = ($urandom_range(0, 3) != 0);
            dv = $urandom_range(0, 1) == 1;
            ea = ($urandom_range(0, 9) < 7);
            br = {($urandom_range(0, 9) < 3), $urandom()};
            if (br[32] && dv && ea) da = 1'b1;
            step(r, da, dv, ea, br);
        end
        wait_cnt = 0;
        while (q_exp.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        check("scoreboard_drained", 64'(q_exp.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
